cosine_ctrl: RTL and testbench
==============================

// Module: cosine_ctrl
// PURPOSE
// - FSM sequencer for the Q8.8 Taylor-series cosine datapath (x_reg, y_reg, temp/ans regs, mult, adder, sign FF, 1/k ROM counter).
// - Per term: temp <= temp*x*(1/k) twice (k from ROM), test term against threshold y, then add/subtract into ans with alternating sign.
// - Stops on term < y or after MAX_TERMS terms; pulses ans_ready. One controller per datapath, no sharing.
// PARAMETERS
// - MAX_TERMS  5  series terms after the leading 1.0; legal 1..6 (ROM holds 1/1..1/12).
// PORTS
// - clk        in   1  clock, rising edge
// - rst        in   1  reset, asynchronous, active-high
// - start      in   1  request new evaluation; sampled only in IDLE
// - neg_flag   in   1  adder MSB from datapath; meaningful only in CHECK
// - busy       out  1  high in every state except IDLE
// - init_0, ld_x, ld_y, i_ans, i_temp, idff  out 1 each  LOAD-state strobes
// - x_en, rom_en, ld_temp, cnt_en, ff_en      out 1 each  multiply-phase strobes
// - y_en, ans_en, ld_ans                      out 1 each  compare/accumulate strobes
// - ans_ready  out  1  one-cycle pulse: ans register holds the result
// BEHAVIOUR
// - Reset: state IDLE, internal term counter 0, all outputs 0. rst mid-run aborts immediately; no ans_ready.
// - All outputs Moore-decoded from state; registered state, no combinational input->output path.
// - IDLE: busy=0. start=1 -> LOAD.
// - LOAD: init_0=ld_x=ld_y=i_ans=i_temp=idff=1 (ans=temp=1.0, ROM count=0, sign FF=0, term cnt=0) -> MX1.
// - MX1: x_en=ld_temp=1, ff_en=1 (sign toggles; term1 subtracts) -> MR1.
// - MR1: rom_en=ld_temp=cnt_en=1 -> MX2.   MX2: x_en=ld_temp=1 -> MR2.
// - MR2: rom_en=ld_temp=cnt_en=1; term cnt+1 -> CHECK.
// - CHECK: y_en=1 (adder computes temp-y). neg_flag=1 -> DONE (term not accumulated); else -> ACCUM.
// - ACCUM: ans_en=ld_ans=1 (ans +/- temp per sign FF). term cnt==MAX_TERMS -> DONE; else -> MX1.
// - DONE: ans_ready=1, busy=1 for exactly one cycle -> IDLE unconditionally.
// - Never assert x_en with rom_en, or y_en with ans_en, in the same cycle.
// - Timing (start sampled at edge 0): LOAD cycle 1; term n occupies cycles 6n-4..6n+1;
//   full run DONE at cycle 6*MAX_TERMS+2; early stop at term k: DONE at cycle 6k+1.
// - start while busy ignored (no queueing). start held high: next LOAD two cycles after DONE (via IDLE).
// - Term counter 3 bits, never wraps (bounded by MAX_TERMS<=6). ROM count reaches 2*MAX_TERMS<=12.
// CONFIGURATION
// - COS_CTRL_ABORT_EN defined: adds input abort (1b). abort=1 in any non-IDLE state -> IDLE next edge,
//   all strobes 0, no ans_ready; abort has priority over every transition incl. DONE. abort in IDLE ignored.
// - Undefined: no abort port; run only ends via DONE or rst.
// TESTING
// - Reset: rst=1 mid-MX2 -> all outputs 0, busy=0 same cycle; after release start runs normally from LOAD.
// - neg_flag tied 0, MAX_TERMS=5, start pulse at edge 0 -> ans_ready only at cycle 32; 5 ff_en, 10 cnt_en, 5 ld_ans pulses.
// - neg_flag=1 in first CHECK -> ans_ready at cycle 7, zero ld_ans pulses, busy low at cycle 8.
// - start pulsed every cycle through a run -> no re-LOAD while busy; next LOAD at cycle 34 (MAX_TERMS=5).
// - With datapath: data_x=16'h0100 (1.0), data_y=8'h01 -> ans within +/-3 LSB of 16'h008A (cos 1 = 0.540).
// - With datapath: data_x=16'h0000 -> term=0<y, stop in first CHECK, ans=16'h0100.
// - COS_CTRL_ABORT_EN: abort=1 in cycle 10 -> IDLE at cycle 11, no ans_ready; new start completes normally.

Source files
------------

// File: rtl/cosine_ctrl.sv
// Moore FSM sequencing the Q8.8 Taylor-series cosine datapath (two multiplies per term, compare, accumulate).
// Optional abort input is compiled in when COS_CTRL_ABORT_EN is defined.
module cosine_ctrl #(
  parameter int MAX_TERMS = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic neg_flag,
`ifdef COS_CTRL_ABORT_EN
  input  logic abort,
`endif
  output logic busy,
  output logic init_0,
  output logic ld_x,
  output logic ld_y,
  output logic i_ans,
  output logic i_temp,
  output logic idff,
  output logic x_en,
  output logic rom_en,
  output logic ld_temp,
  output logic cnt_en,
  output logic ff_en,
  output logic y_en,
  output logic ans_en,
  output logic ld_ans,
  output logic ans_ready
);

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    MX1,
    MR1,
    MX2,
    MR2,
    CHECK,
    ACCUM,
    DONE
  } state_t;

  // MAX_TERMS is limited to 1..6 by the 1/k ROM depth, so three bits never wrap.
  localparam logic [2:0] LAST_TERM = 3'(MAX_TERMS);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] term_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      term_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == LOAD) begin
        term_cnt <= '0;
      end else if (state == MR2) begin
        term_cnt <= term_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    init_0    = 1'b0;
    ld_x      = 1'b0;
    ld_y      = 1'b0;
    i_ans     = 1'b0;
    i_temp    = 1'b0;
    idff      = 1'b0;
    x_en      = 1'b0;
    rom_en    = 1'b0;
    ld_temp   = 1'b0;
    cnt_en    = 1'b0;
    ff_en     = 1'b0;
    y_en      = 1'b0;
    ans_en    = 1'b0;
    ld_ans    = 1'b0;
    ans_ready = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        init_0    = 1'b1;
        ld_x      = 1'b1;
        ld_y      = 1'b1;
        i_ans     = 1'b1;
        i_temp    = 1'b1;
        idff      = 1'b1;
        state_nxt = MX1;
      end
      // The sign FF toggles once per term, so the first term subtracts.
      MX1: begin
        x_en      = 1'b1;
        ld_temp   = 1'b1;
        ff_en     = 1'b1;
        state_nxt = MR1;
      end
      MR1: begin
        rom_en    = 1'b1;
        ld_temp   = 1'b1;
        cnt_en    = 1'b1;
        state_nxt = MX2;
      end
      MX2: begin
        x_en      = 1'b1;
        ld_temp   = 1'b1;
        state_nxt = MR2;
      end
      MR2: begin
        rom_en    = 1'b1;
        ld_temp   = 1'b1;
        cnt_en    = 1'b1;
        state_nxt = CHECK;
      end
      CHECK: begin
        y_en      = 1'b1;
        state_nxt = neg_flag ? DONE : ACCUM;
      end
      ACCUM: begin
        ans_en    = 1'b1;
        ld_ans    = 1'b1;
        state_nxt = (term_cnt == LAST_TERM) ? DONE : MX1;
      end
      DONE: begin
        ans_ready = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
`ifdef COS_CTRL_ABORT_EN
    // Abort overrides every transition, including DONE, so no ans_ready follows it.
    if (abort && (state != IDLE)) state_nxt = IDLE;
`endif
  end

endmodule

// File: tb/tb_cosine_ctrl.sv
// Scoreboard bench for cosine_ctrl: random runs with a predicted completion time and pulse counts per run.
// Covers reset, early stop, held start and (with COS_CTRL_ABORT_EN) abort.
module tb_cosine_ctrl;

  localparam int MAX_TERMS = 5;

  typedef struct {
    int load_cyc;
    int done_cyc;
    int ff;
    int cnt;
    int ld;
  } exp_t;

  logic clk;
  logic rst;
  logic start;
  logic neg_flag;
`ifdef COS_CTRL_ABORT_EN
  logic abort;
`endif
  logic busy, init_0, ld_x, ld_y, i_ans, i_temp, idff;
  logic x_en, rom_en, ld_temp, cnt_en, ff_en;
  logic y_en, ans_en, ld_ans, ans_ready;
  logic [15:0] all_outs;

  int   cyc = 0;
  int   stop_term = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  cosine_ctrl #(.MAX_TERMS(MAX_TERMS)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .neg_flag(neg_flag),
`ifdef COS_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy),
    .init_0(init_0),
    .ld_x(ld_x),
    .ld_y(ld_y),
    .i_ans(i_ans),
    .i_temp(i_temp),
    .idff(idff),
    .x_en(x_en),
    .rom_en(rom_en),
    .ld_temp(ld_temp),
    .cnt_en(cnt_en),
    .ff_en(ff_en),
    .y_en(y_en),
    .ans_en(ans_en),
    .ld_ans(ld_ans),
    .ans_ready(ans_ready)
  );

  assign all_outs = {busy, init_0, ld_x, ld_y, i_ans, i_temp, idff, x_en,
                     rom_en, ld_temp, cnt_en, ff_en, y_en, ans_en, ld_ans, ans_ready};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference: a run of n terms spends six cycles per term after LOAD; an early
  // stop at term k skips that term's accumulate and reports one cycle sooner.
  function automatic exp_t predict(input int stop, input int base);
    exp_t e;
    int   terms;
    bit   early;
    early      = (stop >= 1) && (stop <= MAX_TERMS);
    terms      = early ? stop : MAX_TERMS;
    e.load_cyc = base + 1;
    e.done_cyc = base + (early ? 6 * stop + 1 : 6 * MAX_TERMS + 2);
    e.ff       = terms;
    e.cnt      = 2 * terms;
    e.ld       = early ? terms - 1 : terms;
    return e;
  endfunction

  task automatic applyStimulus(input int stop, input bit hold, input bit noise);
    exp_t e1, e2;
    int   base, base2, last;
    @(negedge clk);
    base      = cyc;
    base2     = 0;
    stop_term = stop;
    e1        = predict(stop, base);
    sb.push_back(e1);
    start = 1'b1;
    if (hold) begin
      base2 = e1.done_cyc + 1;
      e2    = predict(stop, base2);
      sb.push_back(e2);
      last  = e2.done_cyc + 2;
    end else begin
      last = e1.done_cyc + 2;
    end
    while (cyc < last) begin
      @(negedge clk);
      if (hold) start = (cyc <= base2);
      else start = (noise && (cyc <= e1.done_cyc)) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 1'b0;
    checkOutput("sb_drained", sb.size(), 0);
    sb.delete();
  endtask

  // Datapath stand-in: the term falls below y in CHECK number stop_term; neg_flag is noise elsewhere.
  initial begin
    int checks;
    checks   = 0;
    neg_flag = 1'b0;
    forever begin
      @(negedge clk);
      if (init_0 || rst) checks = 0;
      if (y_en) begin
        checks++;
        neg_flag = (checks == stop_term);
      end else begin
        neg_flag = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    int   ffc, cc, lc;
    bit   after;
    exp_t e;
    ffc = 0; cc = 0; lc = 0; after = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ffc = 0; cc = 0; lc = 0; after = 1'b0;
      end else begin
        if (after) begin
          checkOutput("idle_after_done", {busy, ans_ready}, 0);
          after = 1'b0;
        end
        checkOutput("x_en_rom_en_excl", x_en & rom_en, 0);
        checkOutput("y_en_ans_en_excl", y_en & ans_en, 0);
        if (|all_outs[14:0]) checkOutput("busy_with_strobe", busy, 1);
        if (init_0) begin
          ffc = 0; cc = 0; lc = 0;
          if (sb.size() != 0) checkOutput("load_cycle", cyc, sb[0].load_cyc);
        end
        ffc += int'(ff_en);
        cc  += int'(cnt_en);
        lc  += int'(ld_ans);
        if (ans_ready) begin
          if (sb.size() == 0) begin
            checkOutput("unexpected_ans_ready", 1, 0);
          end else begin
            e = sb.pop_front();
            checkOutput("done_cycle", cyc, e.done_cyc);
            checkOutput("ff_en_pulses", ffc, e.ff);
            checkOutput("cnt_en_pulses", cc, e.cnt);
            checkOutput("ld_ans_pulses", lc, e.ld);
          end
          after = 1'b1;
        end
      end
    end
  end

  initial begin
`ifdef COS_CTRL_ABORT_EN
    int base;
    abort = 1'b0;
`endif
    rst   = 1'b1;
    start = 1'b0;
    #3;
    checkOutput("reset_outputs", all_outs, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of MX2 clears the outputs without waiting for a clock edge.
    stop_term = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("load_init_0", init_0, 1);
    repeat (3) @(posedge clk);
    #2;
    checkOutput("mid_run_x_en", x_en, 1);
    rst = 1'b1;
    #1;
    checkOutput("async_reset_outputs", all_outs, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    applyStimulus(0, 1'b0, 1'b0);
    applyStimulus(1, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 1'b0);
    applyStimulus(3, 1'b0, 1'b1);
    applyStimulus(MAX_TERMS, 1'b0, 1'b1);

`ifdef COS_CTRL_ABORT_EN
    stop_term = 0;
    @(negedge clk);
    base  = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < base + 10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    checkOutput("abort_to_idle", all_outs, 0);
    abort = 1'b0;
    repeat (40) @(negedge clk);
    applyStimulus(0, 1'b0, 1'b0);
`endif

    for (int i = 0; i < 14; i++) begin
      applyStimulus($urandom_range(0, MAX_TERMS), ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    checkOutput("sb_final_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
